// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential shift-add-3 binary-to-BCD converter, valid/ready on both sides
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4,
  parameter int SIGNED = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BIN_W-1:0]      bin,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  sign,
  output logic                  overflow,
  output logic [DIGITS-1:0]     blank_mask
);

  localparam int CW = $clog2(BIN_W);
  localparam int BW = 4 * DIGITS;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_e;

  state_e            state_q, state_d;
  logic [BIN_W-1:0]  mag_q, mag_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [BW-1:0]     adj;
  logic              sign_q, sign_d;
  logic              ovf_q, ovf_d;
  logic              fin_q, fin_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [BIN_W-1:0]  neg_bin;
  logic              is_neg;
  logic              zero_run;

  assign neg_bin = ~bin + 1'b1;
  assign is_neg  = (SIGNED != 0) && bin[BIN_W-1];

  always_comb begin
    adj = bcd_q;
    for (int i = 0; i < DIGITS; i++) begin
      adj[4*i +: 4] = (bcd_q[4*i +: 4] > 4'd4) ? bcd_q[4*i +: 4] + 4'd3 : bcd_q[4*i +: 4];
    end
  end

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    fin_d   = fin_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mag_d   = is_neg ? neg_bin : bin;
          sign_d  = is_neg;
          bcd_d   = '0;
          ovf_d   = 1'b0;
          fin_d   = 1'b0;
          cnt_d   = CW'(BIN_W - 1);
          state_d = CONV;
        end
      end
      CONV: begin
        // after the last shift, one settle cycle before presenting the result
        if (fin_q) begin
          fin_d   = 1'b0;
          state_d = DONE;
        end else begin
          bcd_d = {adj[BW-2:0], mag_q[cnt_q]};
          if (adj[BW-1]) ovf_d = 1'b1;
          if (cnt_q == '0) fin_d = 1'b1;
          else             cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mag_q   <= '0;
      bcd_q   <= '0;
      sign_q  <= 1'b0;
      ovf_q   <= 1'b0;
      fin_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      sign_q  <= sign_d;
      ovf_q   <= ovf_d;
      fin_q   <= fin_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign out_bcd   = bcd_q;
  assign sign      = sign_q;
  assign overflow  = ovf_q;

  // digit 0 is never blanked so a zero result still shows one "0"
  always_comb begin
    zero_run   = 1'b1;
    blank_mask = '0;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      zero_run      = zero_run && (bcd_q[4*i +: 4] == 4'd0);
      blank_mask[i] = zero_run;
    end
  end

endmodule
